// File: rtl/md_if.sv
// EX/ID-side bundle between the pipeline and the multiply/divide sequencer.
interface md_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        id_md;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, flush, id_md,
        input  busy, md_stall, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, id_md,
        output busy, md_stall, hi, lo
    );
endinterface

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, models op latency with a down-counter.
// state | meaning
// IDLE  | no op pending; MTHI/MTLO write directly, mult/div ops are accepted
// RUN   | result latched in pend_q, counter running down to the write-back cycle
module md_ctrl #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input logic  clk,
    input logic  reset_n,
    md_if.slave  bus
);
    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [63:0]        pend_q;
    logic               pend_wr_q;
    logic               busy_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;

    logic               accept;
    logic [63:0]        res_d;
    logic               wr_d;
    logic [31:0]        b_div;
    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;

    assign accept = bus.start & ~busy_q & ~bus.flush;

    // Divide by zero and the INT_MIN/-1 overflow both divide by 1 instead;
    // the latter then naturally yields quotient 0x80000000, remainder 0.
    always_comb begin
        b_div = bus.b;
        if ((bus.b == 32'd0) || ((bus.a == 32'h8000_0000) && (bus.b == 32'hFFFF_FFFF)))
            b_div = 32'd1;
        a_sx  = {{32{bus.a[31]}}, bus.a};
        b_sx  = {{32{bus.b[31]}}, bus.b};
        a_s   = bus.a;
        b_s   = b_div;
        res_d = '0;
        wr_d  = 1'b1;
        case (bus.op)
            3'd0: res_d = a_sx * b_sx;
            3'd1: res_d = {32'd0, bus.a} * {32'd0, bus.b};
            3'd2: begin
                res_d = {a_s % b_s, a_s / b_s};
                wr_d  = (bus.b != 32'd0);
            end
            3'd3: begin
                res_d = {bus.a % b_div, bus.a / b_div};
                wr_d  = (bus.b != 32'd0);
            end
            default: res_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_q    <= '0;
            pend_wr_q <= 1'b0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        case (bus.op)
                            3'd0, 3'd1: begin
                                state_q   <= RUN;
                                busy_q    <= 1'b1;
                                cnt_q     <= CNT_W'(MUL_CYCLES - 1);
                                pend_q    <= res_d;
                                pend_wr_q <= wr_d;
                            end
                            3'd2, 3'd3: begin
                                state_q   <= RUN;
                                busy_q    <= 1'b1;
                                cnt_q     <= CNT_W'(DIV_CYCLES - 1);
                                pend_q    <= res_d;
                                pend_wr_q <= wr_d;
                            end
                            3'd4: hi_q <= bus.a;
                            3'd5: lo_q <= bus.a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        pend_wr_q <= 1'b0;
                    end else if (cnt_q == '0) begin
                        if (pend_wr_q) begin
                            hi_q <= pend_q[63:32];
                            lo_q <= pend_q[31:0];
                        end
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        pend_wr_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.md_stall = bus.id_md & (busy_q | (bus.start & ~bus.op[2] & ~bus.flush));
endmodule
